// File: rtl/text_input_arbiter.sv
// text_input_arbiter
// Shares the single CHAR/WE input of the 80x60 text driver between the UART
// and SPI receivers. Each source owns a byte FIFO; a round-robin arbiter pops
// one byte at a time and paces WE so the driver always finishes a character
// before the next one arrives (DEL gets a longer pause for its erase).
// Optional feature macro: CHAR_FILTER_EN (printable/BS/LF/CR input filter).
module text_input_arbiter #(
    parameter int FIFO_DEPTH     = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int DEL_GAP_CYCLES = 175
) (
    input  logic       CLK_50MHz,
    input  logic       RESET,
    input  logic [7:0] UART_DATA,
    input  logic       UART_VALID,
    input  logic [7:0] SPI_DATA,
    input  logic       SPI_VALID,
    input  logic       OVF_CLR,
    output logic [7:0] CHAR,
    output logic       WE,
    output logic       UART_FULL,
    output logic       SPI_FULL,
    output logic       UART_OVF,
    output logic       SPI_OVF,
    output logic       BUSY
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int MAX_GAP = (GAP_CYCLES > DEL_GAP_CYCLES) ? GAP_CYCLES : DEL_GAP_CYCLES;
    localparam int HW      = $clog2(MAX_GAP + 1);

    localparam logic GRANT_UART = 1'b0;
    localparam logic GRANT_SPI  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [HW-1:0]   hold_cnt_r, hold_cnt_s;
    logic [7:0]      char_r, char_s;
    logic            we_r, we_s;
    logic            last_grant_r, last_grant_s;
    logic            arb_en_s, grant_uart_s;

    logic [7:0]      uart_mem_r [FIFO_DEPTH];
    logic [7:0]      spi_mem_r  [FIFO_DEPTH];
    logic [AW-1:0]   uart_wr_ptr_r, uart_rd_ptr_r, spi_wr_ptr_r, spi_rd_ptr_r;
    logic [CW-1:0]   uart_cnt_r, uart_cnt_s, spi_cnt_r, spi_cnt_s;
    logic            uart_full_r, spi_full_r, uart_ovf_r, spi_ovf_r, busy_r;
    logic            uart_accept_s, spi_accept_s;
    logic            uart_push_s, spi_push_s, uart_drop_s, spi_drop_s;
    logic            uart_pop_s, spi_pop_s;
    logic            uart_ne_s, spi_ne_s;

`ifdef CHAR_FILTER_EN
    // Accepts printable ASCII (incl. DEL) plus backspace, line feed and carriage return.
    function automatic logic char_allowed(input logic [7:0] c);
        return ((c >= 8'h20) && (c <= 8'h7F)) || (c == 8'h08) || (c == 8'h0A) || (c == 8'h0D);
    endfunction

    assign uart_accept_s = UART_VALID && char_allowed(UART_DATA);
    assign spi_accept_s  = SPI_VALID  && char_allowed(SPI_DATA);
`else
    assign uart_accept_s = UART_VALID;
    assign spi_accept_s  = SPI_VALID;
`endif

    // A full FIFO drops the byte even when a pop frees a slot in the same cycle.
    assign uart_push_s  = uart_accept_s && (uart_cnt_r != CW'(FIFO_DEPTH));
    assign uart_drop_s  = uart_accept_s && (uart_cnt_r == CW'(FIFO_DEPTH));
    assign spi_push_s   = spi_accept_s  && (spi_cnt_r  != CW'(FIFO_DEPTH));
    assign spi_drop_s   = spi_accept_s  && (spi_cnt_r  == CW'(FIFO_DEPTH));
    assign uart_ne_s    = (uart_cnt_r != CW'(0));
    assign spi_ne_s     = (spi_cnt_r  != CW'(0));
    assign grant_uart_s = uart_ne_s && (!spi_ne_s || (last_grant_r == GRANT_SPI));

    // Next-state, pacing counter and pop/grant decisions of the output FSM.
    always_comb begin
        state_s      = state_r;
        hold_cnt_s   = hold_cnt_r;
        char_s       = char_r;
        we_s         = 1'b0;
        last_grant_s = last_grant_r;
        arb_en_s     = 1'b0;
        uart_pop_s   = 1'b0;
        spi_pop_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                arb_en_s = 1'b1;
            end
            ST_ISSUE: begin
                hold_cnt_s = (char_r == 8'h7F) ? HW'(DEL_GAP_CYCLES) : HW'(GAP_CYCLES);
                state_s    = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_cnt_r <= HW'(1)) begin
                    // Last low cycle: arbitrate now so the next WE follows with no extra gap.
                    arb_en_s = 1'b1;
                    state_s  = ST_IDLE;
                end else begin
                    hold_cnt_s = hold_cnt_r - HW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (arb_en_s && grant_uart_s) begin
            uart_pop_s   = 1'b1;
            char_s       = uart_mem_r[uart_rd_ptr_r];
            we_s         = 1'b1;
            last_grant_s = GRANT_UART;
            state_s      = ST_ISSUE;
        end else if (arb_en_s && spi_ne_s) begin
            spi_pop_s    = 1'b1;
            char_s       = spi_mem_r[spi_rd_ptr_r];
            we_s         = 1'b1;
            last_grant_s = GRANT_SPI;
            state_s      = ST_ISSUE;
        end else begin
            uart_pop_s = 1'b0;
            spi_pop_s  = 1'b0;
        end
    end

    // Next occupancy of both FIFOs from this cycle's push/pop pair.
    always_comb begin
        uart_cnt_s = uart_cnt_r;
        spi_cnt_s  = spi_cnt_r;
        if (uart_push_s && !uart_pop_s) begin
            uart_cnt_s = uart_cnt_r + CW'(1);
        end else if (!uart_push_s && uart_pop_s) begin
            uart_cnt_s = uart_cnt_r - CW'(1);
        end else begin
            uart_cnt_s = uart_cnt_r;
        end
        if (spi_push_s && !spi_pop_s) begin
            spi_cnt_s = spi_cnt_r + CW'(1);
        end else if (!spi_push_s && spi_pop_s) begin
            spi_cnt_s = spi_cnt_r - CW'(1);
        end else begin
            spi_cnt_s = spi_cnt_r;
        end
    end

    // FSM state, pacing counter, grant history and the registered CHAR/WE pair.
    always_ff @(posedge CLK_50MHz) begin
        if (RESET) begin
            state_r      <= ST_IDLE;
            hold_cnt_r   <= HW'(0);
            char_r       <= 8'h00;
            we_r         <= 1'b0;
            last_grant_r <= GRANT_SPI;
        end else begin
            state_r      <= state_s;
            hold_cnt_r   <= hold_cnt_s;
            char_r       <= char_s;
            we_r         <= we_s;
            last_grant_r <= last_grant_s;
        end
    end

    // FIFO storage; contents need no reset because the counts gate every read.
    always_ff @(posedge CLK_50MHz) begin
        if (uart_push_s) begin
            uart_mem_r[uart_wr_ptr_r] <= UART_DATA;
        end
        if (spi_push_s) begin
            spi_mem_r[spi_wr_ptr_r] <= SPI_DATA;
        end
    end

    // FIFO pointers/counts plus the registered FULL, OVF and BUSY status.
    always_ff @(posedge CLK_50MHz) begin
        if (RESET) begin
            uart_wr_ptr_r <= AW'(0);
            uart_rd_ptr_r <= AW'(0);
            spi_wr_ptr_r  <= AW'(0);
            spi_rd_ptr_r  <= AW'(0);
            uart_cnt_r    <= CW'(0);
            spi_cnt_r     <= CW'(0);
            uart_full_r   <= 1'b0;
            spi_full_r    <= 1'b0;
            uart_ovf_r    <= 1'b0;
            spi_ovf_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            if (uart_push_s) uart_wr_ptr_r <= uart_wr_ptr_r + AW'(1);
            if (uart_pop_s)  uart_rd_ptr_r <= uart_rd_ptr_r + AW'(1);
            if (spi_push_s)  spi_wr_ptr_r  <= spi_wr_ptr_r + AW'(1);
            if (spi_pop_s)   spi_rd_ptr_r  <= spi_rd_ptr_r + AW'(1);
            uart_cnt_r  <= uart_cnt_s;
            spi_cnt_r   <= spi_cnt_s;
            uart_full_r <= (uart_cnt_s == CW'(FIFO_DEPTH));
            spi_full_r  <= (spi_cnt_s == CW'(FIFO_DEPTH));
            // A drop in the same cycle as OVF_CLR keeps the flag set.
            if (uart_drop_s)  uart_ovf_r <= 1'b1;
            else if (OVF_CLR) uart_ovf_r <= 1'b0;
            if (spi_drop_s)   spi_ovf_r  <= 1'b1;
            else if (OVF_CLR) spi_ovf_r  <= 1'b0;
            busy_r <= (state_s != ST_IDLE) || (uart_cnt_s != CW'(0)) || (spi_cnt_s != CW'(0));
        end
    end

    assign CHAR      = char_r;
    assign WE        = we_r;
    assign UART_FULL = uart_full_r;
    assign SPI_FULL  = spi_full_r;
    assign UART_OVF  = uart_ovf_r;
    assign SPI_OVF   = spi_ovf_r;
    assign BUSY      = busy_r;

endmodule
